mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, access size codes, grant identifiers and width defaults.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one request/response memory port between the instruction
// fetch side and the load/store side. One transaction is in flight at a time:
// grant (fields latched), address phase until m_addr_ok, data phase until
// m_data_ok. Fetches may be flushed; a flushed fetch still finishes on the bus
// but its completion is hidden from the fetch side.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_done,
    output logic              inst_stall,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              data_stall,

    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    state_t            state, state_next;
    grant_t            last_grant, last_grant_next;
    logic              discard, discard_next;
    logic              lat_wr, lat_wr_next;
    logic [1:0]        lat_size, lat_size_next;
    logic [ADDR_W-1:0] lat_addr, lat_addr_next;
    logic [DATA_W-1:0] lat_wdata, lat_wdata_next;
    logic              inst_eligible;
    logic              data_wins;

    // A fetch being flushed this cycle must never be granted; data wins a tie
    // unless the previous completed transaction was already a data access.
    assign inst_eligible = inst_req & ~inst_cancel;
    assign data_wins     = data_req & (~inst_eligible | (last_grant == GRANT_INST));

    // State, arbitration history, flush flag and latched request fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_INST;
            discard    <= 1'b0;
            lat_wr     <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            discard    <= discard_next;
            lat_wr     <= lat_wr_next;
            lat_size   <= lat_size_next;
            lat_addr   <= lat_addr_next;
            lat_wdata  <= lat_wdata_next;
        end
    end

    // Next-state, grant/latch decisions and the completion pulses.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        discard_next    = discard;
        lat_wr_next     = lat_wr;
        lat_size_next   = lat_size;
        lat_addr_next   = lat_addr;
        lat_wdata_next  = lat_wdata;
        inst_done       = 1'b0;
        data_done       = 1'b0;

        case (state)
            ST_IDLE: begin
                discard_next = 1'b0;
                if (data_wins) begin
                    state_next     = ST_D_ADDR;
                    lat_wr_next    = data_wr;
                    lat_size_next  = data_size;
                    lat_addr_next  = data_addr;
                    lat_wdata_next = data_wdata;
                end else if (inst_eligible) begin
                    state_next     = ST_I_ADDR;
                    lat_wr_next    = 1'b0;
                    lat_size_next  = SIZE_WORD;
                    lat_addr_next  = inst_addr;
                    lat_wdata_next = '0;
                end
            end
            ST_I_ADDR: begin
                if (inst_cancel) begin
                    discard_next = 1'b1;
                end
                if (m_addr_ok) begin
                    state_next = ST_I_DATA;
                end
            end
            ST_I_DATA: begin
                if (m_data_ok) begin
                    inst_done       = ~(discard | inst_cancel);
                    state_next      = ST_IDLE;
                    discard_next    = 1'b0;
                    last_grant_next = GRANT_INST;
                end else if (inst_cancel) begin
                    discard_next = 1'b1;
                end
            end
            ST_D_ADDR: begin
                if (m_addr_ok) begin
                    state_next = ST_D_DATA;
                end
            end
            ST_D_DATA: begin
                if (m_data_ok) begin
                    data_done       = 1'b1;
                    state_next      = ST_IDLE;
                    last_grant_next = GRANT_DATA;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign m_req   = (state == ST_I_ADDR) | (state == ST_D_ADDR);
    assign m_wr    = lat_wr;
    assign m_size  = lat_size;
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

    // Stalls are held low while reset is asserted so the pipeline is released.
    assign inst_stall = resetn & inst_req & ~inst_done & ~inst_cancel;
    assign data_stall = resetn & data_req & ~data_done;

endmodule
